// File: rtl/oam_dma_ctrl_pkg.sv
// Shared bus constants for the OAM DMA controller.
//   dma_state_e       - controller state encoding
//   OAM_DMA_REG_ADDR  - default CPU register that triggers a DMA
//   PPU_OAMDATA_ADDR  - default destination of every DMA write
package oam_dma_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } dma_state_e;

  localparam logic [15:0] OAM_DMA_REG_ADDR = 16'h4014;
  localparam logic [15:0] PPU_OAMDATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller, sitting between the CPU and the peripheral bus.
// A CPU write of a page number to DMA_REG_ADDR halts the CPU and copies
// XFER_LEN bytes from {page, idx} to DEST_ADDR, one read/write pair per byte.
//   clock, nreset             - clock, asynchronous active-low reset
//   cpu_addr/cpu_rw/cpu_data  - CPU bus request (rw: 1 = read)
//   mem_data                  - read data returned by the peripherals
//   bus_addr/bus_rw/bus_data  - peripheral bus (CPU pass-through in IDLE)
//   cpu_rdy                   - 0 halts the CPU
//   busy                      - FSM outside IDLE
//   done                      - one-cycle pulse after the last DMA write
module oam_dma_ctrl
  import oam_dma_ctrl_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = OAM_DMA_REG_ADDR,
  parameter logic [15:0] DEST_ADDR    = PPU_OAMDATA_ADDR,
  parameter int unsigned XFER_LEN     = 256
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_data,
  input  logic [7:0]  mem_data,
  output logic [15:0] bus_addr,
  output logic        bus_rw,
  output logic [7:0]  bus_data,
  output logic        cpu_rdy,
  output logic        busy,
  output logic        done
);

  dma_state_e  state_q, state_d;
  logic        parity_q;
  logic [7:0]  page_q, page_d;
  logic [7:0]  hold_q, hold_d;
  logic [8:0]  idx_q, idx_d;
  logic        done_q, done_d;

  logic        trigger;
  logic [8:0]  idx_inc;
  logic        last_byte;

  assign trigger   = (cpu_addr == DMA_REG_ADDR) && !cpu_rw;
  assign idx_inc   = idx_q + 9'd1;
  assign last_byte = ({23'd0, idx_inc} >= XFER_LEN);

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          page_d  = cpu_data;
          idx_d   = '0;
          state_d = ST_HALT;
        end
      end
      // Parity flips on the exit edge: leaving HALT with parity_q==1 lands
      // READ on parity 0 directly, otherwise one ALIGN cycle is needed.
      ST_HALT:  state_d = parity_q ? ST_READ : ST_ALIGN;
      ST_ALIGN: state_d = ST_READ;
      ST_READ: begin
        hold_d  = mem_data;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        idx_d = idx_inc;
        if (last_byte) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q  <= ST_IDLE;
      parity_q <= 1'b0;
      page_q   <= '0;
      hold_q   <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      page_q   <= page_d;
      hold_q   <= hold_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

  // Bus mux: CPU pass-through in IDLE, FSM-owned otherwise. Source address
  // uses only idx[7:0] so it never carries into the page.
  always_comb begin
    bus_addr = cpu_addr;
    bus_rw   = cpu_rw;
    bus_data = cpu_data;
    unique case (state_q)
      ST_IDLE: ;
      ST_HALT, ST_ALIGN: begin
        bus_addr = cpu_addr;
        bus_rw   = 1'b1;
        bus_data = hold_q;
      end
      ST_READ: begin
        bus_addr = {page_q, idx_q[7:0]};
        bus_rw   = 1'b1;
        bus_data = hold_q;
      end
      ST_WRITE: begin
        bus_addr = DEST_ADDR;
        bus_rw   = 1'b0;
        bus_data = hold_q;
      end
      default: ;
    endcase
  end

  assign cpu_rdy = (state_q == ST_IDLE);
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

  typedef struct packed {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  data;
  } bus_t;

  logic        clock = 1'b0;
  logic        nreset;
  logic        tb_par;

  logic [15:0] cpu_addr0, cpu_addr1;
  logic        cpu_rw0, cpu_rw1;
  logic [7:0]  cpu_data0, cpu_data1;
  logic [7:0]  mem_data0, mem_data1;
  logic [15:0] bus_addr0, bus_addr1;
  logic        bus_rw0, bus_rw1;
  logic [7:0]  bus_data0, bus_data1;
  logic        cpu_rdy0, cpu_rdy1, busy0, busy1, done0, done1;

  bus_t q0[$], q1[$];
  int   lowexp0[$], lowexp1[$];
  int   low0 = 0, low1 = 0;
  int   n_pass = 0, n_total = 0;

  always #5 clock = ~clock;

  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  assign mem_data0 = memf(bus_addr0);
  assign mem_data1 = memf(bus_addr1);

  // Independent parity model: cleared by reset, flips every rising edge.
  always @(posedge clock or negedge nreset)
    if (!nreset) tb_par <= 1'b0;
    else         tb_par <= ~tb_par;

  oam_dma_ctrl u_dut0 (
    .clock(clock), .nreset(nreset),
    .cpu_addr(cpu_addr0), .cpu_rw(cpu_rw0), .cpu_data(cpu_data0), .mem_data(mem_data0),
    .bus_addr(bus_addr0), .bus_rw(bus_rw0), .bus_data(bus_data0),
    .cpu_rdy(cpu_rdy0), .busy(busy0), .done(done0)
  );

  oam_dma_ctrl #(.XFER_LEN(1)) u_dut1 (
    .clock(clock), .nreset(nreset),
    .cpu_addr(cpu_addr1), .cpu_rw(cpu_rw1), .cpu_data(cpu_data1), .mem_data(mem_data1),
    .bus_addr(bus_addr1), .bus_rw(bus_rw1), .bus_data(bus_data1),
    .cpu_rdy(cpu_rdy1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_miss(input string name);
    n_total++;
    $display("FAIL %s: got DUT event, expected none at %0t", name, $time);
  endtask

  // Monitor: pops one expected bus cycle per busy cycle, checks pass-through
  // when idle, and checks the halt length and drained queue on done.
  task automatic mon(input int u, input logic [15:0] ba, input logic brw, input logic [7:0] bd,
                     input logic rdy, input logic bsy, input logic dn,
                     input logic [15:0] ca, input logic crw, input logic [7:0] cd);
    bus_t e;
    bit   have;
    int   le, low, qs;
    if (bsy) begin
      have = (u == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) e = (u == 0) ? q0.pop_front() : q1.pop_front();
      if (!have) chk_miss($sformatf("unexpected_busy_u%0d", u));
      else if (e.rw) chk($sformatf("bus_read_u%0d", u), {ba, brw}, {e.addr, 1'b1});
      else chk($sformatf("bus_write_u%0d", u), {ba, brw, bd}, {e.addr, 1'b0, e.data});
      chk($sformatf("cpu_rdy_low_u%0d", u), rdy, 1'b0);
      if (u == 0) low0++; else low1++;
    end else begin
      chk($sformatf("passthru_u%0d", u), {ba, brw, bd, rdy}, {ca, crw, cd, 1'b1});
    end
    if (dn) begin
      have = (u == 0) ? (lowexp0.size() > 0) : (lowexp1.size() > 0);
      low  = (u == 0) ? low0 : low1;
      qs   = (u == 0) ? q0.size() : q1.size();
      if (!have) chk_miss($sformatf("unexpected_done_u%0d", u));
      else begin
        le = (u == 0) ? lowexp0.pop_front() : lowexp1.pop_front();
        chk($sformatf("halt_len_u%0d", u), low, le);
        chk($sformatf("queue_drained_u%0d", u), qs, 0);
      end
      if (u == 0) low0 = 0; else low1 = 0;
    end
  endtask

  always @(negedge clock) begin
    if (nreset) begin
      mon(0, bus_addr0, bus_rw0, bus_data0, cpu_rdy0, busy0, done0, cpu_addr0, cpu_rw0, cpu_data0);
      mon(1, bus_addr1, bus_rw1, bus_data1, cpu_rdy1, busy1, done1, cpu_addr1, cpu_rw1, cpu_data1);
    end
  end

  task automatic drive(input int u, input logic [15:0] a, input logic rw, input logic [7:0] d);
    if (u == 0) begin cpu_addr0 = a; cpu_rw0 = rw; cpu_data0 = d; end
    else        begin cpu_addr1 = a; cpu_rw1 = rw; cpu_data1 = d; end
  endtask

  // Issues a trigger timed so that an ALIGN cycle is (want_align=1) or is not
  // inserted, then queues the expected bus cycles and halt length.
  task automatic trig(input int u, input logic [7:0] page, input bit want_align, output int a);
    int len;
    logic [15:0] src;
    len = (u == 0) ? 256 : 1;
    @(posedge clock); #1;
    if (tb_par != want_align) begin @(posedge clock); #1; end
    drive(u, 16'h4014, 1'b0, page);
    @(posedge clock); #1;
    // tb_par now equals the parity seen in HALT; ALIGN needed when it is 0.
    a = (tb_par == 1'b0) ? 1 : 0;
    for (int i = 0; i < 1 + a; i++) begin
      if (u == 0) q0.push_back('{addr: 16'h4014, rw: 1'b1, data: 8'h00});
      else        q1.push_back('{addr: 16'h4014, rw: 1'b1, data: 8'h00});
    end
    for (int i = 0; i < len; i++) begin
      src = {page, 8'(i)};
      if (u == 0) begin
        q0.push_back('{addr: src, rw: 1'b1, data: 8'h00});
        q0.push_back('{addr: 16'h2004, rw: 1'b0, data: memf(src)});
      end else begin
        q1.push_back('{addr: src, rw: 1'b1, data: 8'h00});
        q1.push_back('{addr: 16'h2004, rw: 1'b0, data: memf(src)});
      end
    end
    if (u == 0) lowexp0.push_back(1 + a + 2 * len);
    else        lowexp1.push_back(1 + a + 2 * len);
    repeat (1 + a) @(posedge clock);
    #1;
    if (u == 0) begin
      // A second trigger mid-transfer must be ignored.
      drive(0, 16'h4014, 1'b0, 8'h07);
      repeat (6) @(posedge clock);
      #1;
    end
    drive(u, 16'h0000, 1'b1, 8'h00);
  endtask

  task automatic wait_done(input int u);
    int   n = 0;
    logic d = 1'b0;
    while (!d && n < 700) begin
      @(posedge clock); #1;
      d = (u == 0) ? done0 : done1;
      n++;
    end
    chk($sformatf("done_seen_u%0d", u), d, 1'b1);
    repeat (3) @(posedge clock);
  endtask

  initial begin
    int a;
    nreset = 1'b0;
    drive(0, 16'h0000, 1'b1, 8'h00);
    drive(1, 16'h0000, 1'b1, 8'h00);
    #1;
    chk("reset_outputs_u0", {cpu_rdy0, busy0, done0}, 3'b100);
    chk("reset_outputs_u1", {cpu_rdy1, busy1, done1}, 3'b100);
    #22 nreset = 1'b1;

    // CPU read of the DMA register and write to a neighbour: no transfer.
    @(posedge clock); #1;
    drive(0, 16'h4014, 1'b1, 8'h02);
    repeat (4) @(posedge clock);
    #1 drive(0, 16'h4015, 1'b0, 8'h55);
    repeat (4) @(posedge clock);
    #1 drive(0, 16'h1234, 1'b0, 8'hA7);
    repeat (2) @(posedge clock);
    #1 drive(0, 16'h0000, 1'b1, 8'h00);

    trig(0, 8'h02, 1'b0, a); wait_done(0);
    trig(0, 8'h02, 1'b1, a); wait_done(0);

    // Asynchronous reset around byte 100, then a fresh page-3 transfer.
    trig(0, 8'h05, 1'b0, a);
    repeat (193 - a) @(posedge clock);
    #2 nreset = 1'b0;
    #1;
    chk("midxfer_reset_u0", {cpu_rdy0, busy0, done0}, 3'b100);
    q0.delete(); lowexp0.delete(); low0 = 0;
    #20 nreset = 1'b1;
    trig(0, 8'h03, 1'b0, a); wait_done(0);

    trig(1, 8'hFF, 1'b0, a); wait_done(1);
    trig(1, 8'hFF, 1'b1, a); wait_done(1);
    trig(1, 8'h40, 1'b0, a); wait_done(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
